dds_sweep_ctrl: RTL and testbench
=================================

// Module: dds_sweep_ctrl
// PURPOSE
//  Sequencer for the DDS waveform core: drives its frequency control word, phase offset and one-hot
//  wave select. Runs programmable linear frequency sweeps (start/step/stop, per-step dwell), single
//  or continuous, and lets the user rotate the waveform and load a phase offset at any time.
//  Sits between the user-control logic (keys/host) and the DDS phase accumulator.
// PARAMETERS
//  FREQ_W     32     width of frequency words (f_start/f_step/f_stop/freq_word)
//  PHASE_W    12     width of phase offset word
//  DWELL_W    24     width of dwell counter (clock cycles per frequency step)
//  DEF_FREQ   42949  freq_word reset value
//  DEF_PHASE  1024   phase_word reset value
// PORTS
//  sys_clk     in   1        system clock (50 MHz)
//  sys_rst     in   1        synchronous reset, active-high
//  start       in   1        1-cycle pulse: begin sweep (accepted only in IDLE)
//  abort       in   1        1-cycle pulse: stop sweep immediately
//  cont        in   1        level: 1 = restart sweep from f_start after f_stop
//  f_start     in   FREQ_W   first sweep frequency word
//  f_step      in   FREQ_W   increment per step
//  f_stop      in   FREQ_W   upper bound (inclusive)
//  dwell       in   DWELL_W  cycles each frequency is held; 0 treated as 1
//  wave_next   in   1        1-cycle pulse: rotate wave select
//  phase_ld    in   1        1-cycle pulse: load phase_in
//  phase_in    in   PHASE_W  new phase offset
//  freq_word   out  FREQ_W   frequency control word to DDS (registered)
//  phase_word  out  PHASE_W  phase offset to DDS (registered)
//  wave_select out  4        one-hot: 0001 sine, 0010 square, 0100 triangle, 1000 sawtooth
//  busy        out  1        high while sweep in progress
//  done        out  1        1-cycle pulse at sweep completion
//  upd         out  1        1-cycle pulse in the first cycle any output word takes a new value
// BEHAVIOUR
//  Reset: freq_word=DEF_FREQ, phase_word=DEF_PHASE, wave_select=4'b0001, busy=0, done=0, upd=0, state IDLE.
//  FSM states IDLE, RUN, FIN.
//  IDLE: start (and no abort) -> capture f_start/f_step/f_stop/dwell into shadow regs; freq_word<=f_start,
//   busy<=1, upd pulse, dwell counter loaded; -> RUN. Inputs ignored after capture until next IDLE.
//  RUN: each freq_word value is held exactly max(dwell,1) cycles. At end of dwell:
//   next = freq_word + f_step computed FREQ_W+1 bits wide;
//   next <= f_stop and no carry -> freq_word<=next, upd pulse, reload counter, stay RUN;
//   else cont=1 -> freq_word<=f_start, upd pulse, stay RUN; else -> FIN, freq_word unchanged.
//  Degenerate: f_step=0 or f_start>f_stop -> f_start held one dwell, then FIN (cont ignored).
//  FIN: done=1, busy=0 for exactly this one cycle; -> IDLE. freq_word keeps last value.
//  abort in RUN/FIN: next cycle IDLE, busy=0, no done pulse, freq_word holds current value.
//  abort and start same cycle in IDLE: abort wins, start dropped. start while busy: ignored.
//  wave_next: any state, 1-cycle latency, rotate 0001->0010->0100->1000->0001; upd pulse.
//  phase_ld: any state, phase_word<=phase_in next cycle, upd pulse.
//  Simultaneous wave_next/phase_ld/frequency update in one cycle: all applied, single upd pulse.
//  sys_rst mid-sweep: all outputs to reset values next edge, sweep discarded.
//  wave_select always exactly one-hot; no illegal code reachable.
// TESTING
//  T1 f_start=100,f_step=50,f_stop=250,dwell=4,cont=0, start -> freq_word 100,150,200,250 each 4 cycles,
//     upd at each change, then done 1 cycle, busy low, freq_word stays 250.
//  T2 same with cont=1 -> after 250 held 4 cycles freq_word=100, no done; abort -> IDLE, value held, no done.
//  T3 f_start=32'hFFFF_FF00,f_step=32'h200,f_stop=32'hFFFF_FFFF,dwell=2 -> FFFF_FF00 for 2 cycles
//     (carry detected), then done; also f_step=0 and f_start>f_stop -> one value then done.
//  T4 dwell=0 -> each value held 1 cycle; start during busy and start+abort in IDLE -> both ignored.
//  T5 5 wave_next pulses from reset -> 0010,0100,1000,0001,0010, each one cycle after pulse, with upd;
//     phase_ld with phase_in=12'd2048 -> phase_word=2048 next cycle.
//  T6 sys_rst asserted mid-sweep -> next edge freq_word=42949, phase_word=1024, wave_select=0001, busy=0.

Source files
------------

// File: rtl/dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// dds_sweep_ctrl
//   Sequencer for the DDS waveform core. It produces the frequency control
//   word, the phase offset and the one-hot wave select. It runs linear
//   frequency sweeps from f_start to f_stop in steps of f_step, and holds each
//   frequency for 'dwell' cycles. A sweep runs once or repeats continuously.
//   The waveform can be rotated and the phase offset reloaded at any time.
//
// Ports
//   sys_clk      in   system clock
//   sys_rst      in   synchronous reset, active-high
//   start        in   pulse: begin a sweep (accepted only when idle)
//   abort        in   pulse: stop the sweep immediately, no done pulse
//   cont         in   level: restart from f_start after f_stop
//   f_start      in   first sweep frequency word
//   f_step       in   increment per step
//   f_stop       in   inclusive upper bound
//   dwell        in   cycles each frequency is held (0 acts as 1)
//   wave_next    in   pulse: rotate wave select
//   phase_ld     in   pulse: load phase_in into phase_word
//   phase_in     in   new phase offset
//   freq_word    out  frequency control word (registered)
//   phase_word   out  phase offset (registered)
//   wave_select  out  one-hot: 0001 sine, 0010 square, 0100 triangle, 1000 saw
//   busy         out  high while a sweep is running
//   done         out  one-cycle pulse when a sweep completes
//   upd          out  one-cycle pulse in the first cycle an output word changes
// -----------------------------------------------------------------------------
module dds_sweep_ctrl #(
    parameter int          FREQ_W    = 32,
    parameter int          PHASE_W   = 12,
    parameter int          DWELL_W   = 24,
    parameter int unsigned DEF_FREQ  = 42949,
    parameter int unsigned DEF_PHASE = 1024
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               abort,
    input  logic               cont,
    input  logic [FREQ_W-1:0]  f_start,
    input  logic [FREQ_W-1:0]  f_step,
    input  logic [FREQ_W-1:0]  f_stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               wave_next,
    input  logic               phase_ld,
    input  logic [PHASE_W-1:0] phase_in,
    output logic [FREQ_W-1:0]  freq_word,
    output logic [PHASE_W-1:0] phase_word,
    output logic [3:0]         wave_select,
    output logic               busy,
    output logic               done,
    output logic               upd
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state, state_nxt;

    // Sweep settings captured at start; the inputs may change during a sweep.
    logic [FREQ_W-1:0]  sh_start, sh_step, sh_stop;
    logic [DWELL_W-1:0] sh_reload;    // max(dwell,1)-1
    logic               sh_degen;     // step of zero or empty range

    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell_init;
    logic [FREQ_W:0]    freq_sum;
    logic               accept, dwell_end, step_ok, wrap_ok;
    logic               freq_ld;
    logic [FREQ_W-1:0]  freq_nxt;

    assign accept     = (state == IDLE) && start && !abort;
    assign dwell_end  = (state == RUN) && !abort && (dwell_cnt == '0);
    assign dwell_init = (dwell == '0) ? '0 : dwell - DWELL_W'(1);

    // The extra top bit catches wrap-around past the top of the word range.
    assign freq_sum   = {1'b0, freq_word} + {1'b0, sh_step};
    assign step_ok    = !sh_degen && !freq_sum[FREQ_W]
                        && (freq_sum[FREQ_W-1:0] <= sh_stop);
    assign wrap_ok    = !sh_degen && cont;

    // State register
    always_ff @(posedge sys_clk) begin
        if (sys_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN: begin
                if (abort)                              state_nxt = IDLE;
                else if (dwell_end && !step_ok && !wrap_ok) state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = (state == RUN);
        done = (state == FIN);
    end

    // Frequency word selection
    always_comb begin
        freq_ld  = 1'b0;
        freq_nxt = freq_word;
        if (accept) begin
            freq_ld  = 1'b1;
            freq_nxt = f_start;
        end else if (dwell_end) begin
            if (step_ok) begin
                freq_ld  = 1'b1;
                freq_nxt = freq_sum[FREQ_W-1:0];
            end else if (wrap_ok) begin
                freq_ld  = 1'b1;
                freq_nxt = sh_start;
            end
        end
    end

    // Datapath registers
    // NOTE: sequential state uses non-blocking assignments, so every register samples values from before the edge.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            freq_word   <= FREQ_W'(DEF_FREQ);
            phase_word  <= PHASE_W'(DEF_PHASE);
            wave_select <= 4'b0001;
            upd         <= 1'b0;
            dwell_cnt   <= '0;
            sh_start    <= '0;
            sh_step     <= '0;
            sh_stop     <= '0;
            sh_reload   <= '0;
            sh_degen    <= 1'b0;
        end else begin
            if (accept) begin
                sh_start  <= f_start;
                sh_step   <= f_step;
                sh_stop   <= f_stop;
                sh_reload <= dwell_init;
                sh_degen  <= (f_step == '0) || (f_start > f_stop);
            end

            if (accept)
                dwell_cnt <= dwell_init;
            else if (state == RUN && !abort)
                dwell_cnt <= (dwell_cnt == '0) ? sh_reload : dwell_cnt - DWELL_W'(1);

            if (freq_ld)   freq_word   <= freq_nxt;
            if (phase_ld)  phase_word  <= phase_in;
            // A rotation of a one-hot value is always one-hot.
            if (wave_next) wave_select <= {wave_select[2:0], wave_select[3]};

            upd <= freq_ld || phase_ld || wave_next;
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dds_sweep_ctrl
//   Directed self-checking bench for dds_sweep_ctrl. The bench drives inputs
//   one time unit after each rising edge. It samples outputs at the same point,
//   so each check sees the state left by the edge just before it.
// -----------------------------------------------------------------------------
module tb_dds_sweep_ctrl;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        start, abort, cont;
    logic [31:0] f_start, f_step, f_stop;
    logic [23:0] dwell;
    logic        wave_next, phase_ld;
    logic [11:0] phase_in;
    logic [31:0] freq_word;
    logic [11:0] phase_word;
    logic [3:0]  wave_select;
    logic        busy, done, upd;

    int n_vec  = 0;
    int n_miss = 0;

    dds_sweep_ctrl dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start       (start),
        .abort       (abort),
        .cont        (cont),
        .f_start     (f_start),
        .f_step      (f_step),
        .f_stop      (f_stop),
        .dwell       (dwell),
        .wave_next   (wave_next),
        .phase_ld    (phase_ld),
        .phase_in    (phase_in),
        .freq_word   (freq_word),
        .phase_word  (phase_word),
        .wave_select (wave_select),
        .busy        (busy),
        .done        (done),
        .upd         (upd)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v)
        else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_outs(input string tag, input logic [31:0] f, input logic b,
                            input logic d, input logic u);
        chk({tag, ".freq"}, freq_word, f);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".upd"},  32'(upd),  32'(u));
    endtask

    int          sweep_vals [4] = '{100, 150, 200, 250};
    logic [3:0]  wave_exp   [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};

    initial begin
        sys_rst = 1'b1; start = 0; abort = 0; cont = 0;
        f_start = 0; f_step = 0; f_stop = 0; dwell = 0;
        wave_next = 0; phase_ld = 0; phase_in = 0;
        tick(); tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        chk_outs("reset", 32'd42949, 0, 0, 0);
        chk("reset.phase", 32'(phase_word), 32'd1024);
        chk("reset.wave",  32'(wave_select), 32'h1);

        // T1: single sweep 100..250 step 50, dwell 4
        f_start = 100; f_step = 50; f_stop = 250; dwell = 4; cont = 0;
        start = 1; tick(); start = 0;
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < 4; k++) begin
                chk_outs($sformatf("t1.v%0d.c%0d", v, k), 32'(sweep_vals[v]), 1, 0, k == 0);
                tick();
            end
        chk_outs("t1.fin", 32'd250, 0, 1, 0);
        tick();
        chk_outs("t1.idle", 32'd250, 0, 0, 0);

        // T2: continuous sweep wraps to f_start, then abort
        cont = 1;
        start = 1; tick(); start = 0;
        for (int v = 0; v < 4; v++)
            for (int k = 0; k < 4; k++) begin
                chk_outs($sformatf("t2.v%0d.c%0d", v, k), 32'(sweep_vals[v]), 1, 0, k == 0);
                tick();
            end
        chk_outs("t2.wrap", 32'd100, 1, 0, 1);
        tick();
        abort = 1; tick(); abort = 0;
        chk_outs("t2.abort", 32'd100, 0, 0, 0);
        tick();
        chk_outs("t2.after", 32'd100, 0, 0, 0);
        cont = 0;

        // T3a: carry out of the word range ends the sweep
        f_start = 32'hFFFF_FF00; f_step = 32'h200; f_stop = 32'hFFFF_FFFF; dwell = 2;
        start = 1; tick(); start = 0;
        chk_outs("t3.c0", 32'hFFFF_FF00, 1, 0, 1);
        tick();
        chk_outs("t3.c1", 32'hFFFF_FF00, 1, 0, 0);
        tick();
        chk_outs("t3.fin", 32'hFFFF_FF00, 0, 1, 0);
        tick();

        // T3b: f_step = 0 holds one dwell then finishes, cont ignored
        cont = 1; f_start = 500; f_step = 0; f_stop = 1000; dwell = 1;
        start = 1; tick(); start = 0;
        chk_outs("t3.step0", 32'd500, 1, 0, 1);
        tick();
        chk_outs("t3.step0.fin", 32'd500, 0, 1, 0);
        tick();

        // T3c: f_start > f_stop holds one dwell then finishes, cont ignored
        f_start = 900; f_step = 10; f_stop = 800;
        start = 1; tick(); start = 0;
        chk_outs("t3.inv", 32'd900, 1, 0, 1);
        tick();
        chk_outs("t3.inv.fin", 32'd900, 0, 1, 0);
        tick();
        cont = 0;

        // T4: dwell 0 acts as 1; start while busy is ignored
        f_start = 10; f_step = 5; f_stop = 20; dwell = 0;
        start = 1; tick();
        f_start = 999;
        chk_outs("t4.v10", 32'd10, 1, 0, 1);
        tick(); start = 0;
        chk_outs("t4.v15", 32'd15, 1, 0, 1);
        tick();
        chk_outs("t4.v20", 32'd20, 1, 0, 1);
        tick();
        chk_outs("t4.fin", 32'd20, 0, 1, 0);
        tick();
        // start and abort together in idle: abort wins
        f_start = 777; start = 1; abort = 1; tick(); start = 0; abort = 0;
        chk_outs("t4.startabort", 32'd20, 0, 0, 0);
        tick();
        chk_outs("t4.startabort2", 32'd20, 0, 0, 0);

        // T5: wave rotation from reset, then phase load
        sys_rst = 1; tick(); sys_rst = 0;
        for (int i = 0; i < 5; i++) begin
            wave_next = 1; tick(); wave_next = 0;
            chk($sformatf("t5.wave%0d", i), 32'(wave_select), 32'(wave_exp[i]));
            chk($sformatf("t5.upd%0d", i),  32'(upd), 32'd1);
            tick();
            chk($sformatf("t5.hold%0d", i), 32'(wave_select), 32'(wave_exp[i]));
            chk($sformatf("t5.updlo%0d", i), 32'(upd), 32'd0);
        end
        phase_in = 12'd2048; phase_ld = 1; tick(); phase_ld = 0;
        chk("t5.phase", 32'(phase_word), 32'd2048);
        chk("t5.phase.upd", 32'(upd), 32'd1);
        tick();
        chk("t5.phase.updlo", 32'(upd), 32'd0);
        // wave_next and phase_ld together: both applied, one upd pulse
        phase_in = 12'd5; phase_ld = 1; wave_next = 1; tick(); phase_ld = 0; wave_next = 0;
        chk("t5.both.wave",  32'(wave_select), 32'h4);
        chk("t5.both.phase", 32'(phase_word), 32'd5);
        chk("t5.both.upd",   32'(upd), 32'd1);
        tick();
        chk("t5.both.updlo", 32'(upd), 32'd0);

        // T6: reset in the middle of a sweep
        f_start = 100; f_step = 50; f_stop = 250; dwell = 4; cont = 1;
        start = 1; tick(); start = 0;
        tick(); tick(); tick(); tick(); tick();
        chk_outs("t6.pre", 32'd150, 1, 0, 0);
        sys_rst = 1; tick();
        chk_outs("t6.rst", 32'd42949, 0, 0, 0);
        chk("t6.rst.phase", 32'(phase_word), 32'd1024);
        chk("t6.rst.wave",  32'(wave_select), 32'h1);
        sys_rst = 0; tick(); tick();
        chk_outs("t6.post", 32'd42949, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
